// File: rtl/out_requant_writer_if.sv
// Job control, array-result and buffer-write bundle for out_requant_writer.
// master drives jobs and array results; slave is the writer.
interface out_requant_writer_if #(
    parameter int num_pe_row         = 4,
    parameter int out_fr_array_width = 24,
    parameter int data_width_to_buff = 16,
    parameter int addr_width         = 13
);
    logic                                       start;
    logic [addr_width-1:0]                      base_addr;
    logic [addr_width:0]                        num_outputs;
    logic [3:0]                                 shift_amt;
    logic                                       array_out_valid;
    logic [num_pe_row*out_fr_array_width-1:0]   array_out_even_col;
    logic [num_pe_row*out_fr_array_width-1:0]   array_out_odd_col;
    logic [num_pe_row*data_width_to_buff-1:0]   buff_data_in_even;
    logic [num_pe_row*data_width_to_buff-1:0]   buff_data_in_odd;
    logic [num_pe_row-1:0]                      wEn_even_AH;
    logic [num_pe_row-1:0]                      wEn_odd_AH;
    logic [num_pe_row*addr_width-1:0]           wAddr_even;
    logic [num_pe_row*addr_width-1:0]           wAddr_odd;
    logic                                       busy;
    logic                                       done;
    logic [15:0]                                sat_count;

    modport master (
        output start, base_addr, num_outputs, shift_amt,
        output array_out_valid, array_out_even_col, array_out_odd_col,
        input  buff_data_in_even, buff_data_in_odd,
        input  wEn_even_AH, wEn_odd_AH, wAddr_even, wAddr_odd,
        input  busy, done, sat_count
    );

    modport slave (
        input  start, base_addr, num_outputs, shift_amt,
        input  array_out_valid, array_out_even_col, array_out_odd_col,
        output buff_data_in_even, buff_data_in_odd,
        output wEn_even_AH, wEn_odd_AH, wAddr_even, wAddr_odd,
        output busy, done, sat_count
    );
endinterface

// File: rtl/out_requant_writer.sv
// Requantising writer: array results -> rounded/saturated buffer writes.
// Optional macro OUT_REQUANT_RELU_EN clamps every lane result at zero.
module out_requant_writer #(
    parameter int num_pe_row         = 4,
    parameter int out_fr_array_width = 24,
    parameter int data_width_to_buff = 16,
    parameter int nb_data            = 8192,
    parameter int addr_width         = $clog2(nb_data)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    out_requant_writer_if.slave   bus
);
    localparam int R  = num_pe_row;
    localparam int OW = out_fr_array_width;
    localparam int DW = data_width_to_buff;
    localparam int AW = addr_width;

    localparam logic signed [OW:0] MAXV = {{(OW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [OW:0] MINV = {{(OW-DW+2){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [AW-1:0]      LAST = AW'(nb_data - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [AW:0]       num_q;
    logic [AW:0]       accepted;
    logic [3:0]        shift_q;
    logic [AW-1:0]     next_addr;
    logic              accept;

    logic              v1;
    logic [AW-1:0]     a1;
    logic [R*OW-1:0]   e1;
    logic [R*OW-1:0]   o1;

    logic [R*DW-1:0]   q_even;
    logic [R*DW-1:0]   q_odd;
    logic [16:0]       nsat;
    logic [16:0]       sat_sum;
    logic [15:0]       sat_next;
    logic [DW:0]       re;
    logic [DW:0]       ro;

    // Returns {saturated, value}; the rounding add has one guard bit.
    function automatic logic [DW:0] requant(
        input logic signed [OW-1:0] x,
        input logic [3:0]           s
    );
        logic signed [OW:0]   rc;
        logic signed [OW:0]   y;
        logic                 pos;
        logic                 neg;
        logic [DW-1:0]        r;
        rc = '0;
        if (s != 4'd0) rc[s - 4'd1] = 1'b1;
        y   = ($signed({x[OW-1], x}) + rc) >>> s;
        pos = (y > MAXV);
        neg = (y < MINV);
        r   = pos ? MAXV[DW-1:0] : (neg ? MINV[DW-1:0] : y[DW-1:0]);
`ifdef OUT_REQUANT_RELU_EN
        if (r[DW-1]) r = '0;
        neg = 1'b0;
`endif
        return {pos | neg, r};
    endfunction

    assign accept = (state == RUN) && bus.array_out_valid && (accepted < num_q);

    // Per-lane requant of the stage-1 beat and count of saturated lanes.
    always_comb begin
        q_even = '0;
        q_odd  = '0;
        nsat   = '0;
        re     = '0;
        ro     = '0;
        for (int r = 0; r < R; r++) begin
            re = requant(e1[r*OW +: OW], shift_q);
            ro = requant(o1[r*OW +: OW], shift_q);
            q_even[r*DW +: DW] = re[DW-1:0];
            q_odd[r*DW +: DW]  = ro[DW-1:0];
            nsat = nsat + {16'd0, re[DW]} + {16'd0, ro[DW]};
        end
        sat_sum  = {1'b0, bus.sat_count} + nsat;
        sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    // Job FSM: latch job parameters, count accepted beats, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            num_q     <= '0;
            accepted  <= '0;
            shift_q   <= '0;
            next_addr <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        bus.busy  <= 1'b1;
                        num_q     <= bus.num_outputs;
                        shift_q   <= bus.shift_amt;
                        accepted  <= '0;
                        next_addr <= bus.base_addr;
                    end
                end
                RUN: begin
                    if (accept) begin
                        accepted  <= accepted + 1'b1;
                        next_addr <= (next_addr == LAST) ? '0 : next_addr + 1'b1;
                    end
                    if (accepted == num_q) state <= DRAIN;
                end
                DRAIN: begin
                    if (!v1) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: capture an accepted beat with its write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
            e1 <= '0;
            o1 <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                a1 <= next_addr;
                e1 <= bus.array_out_even_col;
                o1 <= bus.array_out_odd_col;
            end
        end
    end

    // Stage 2: register requantised data, enables, addresses, sat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wEn_even_AH       <= '0;
            bus.wEn_odd_AH        <= '0;
            bus.buff_data_in_even <= '0;
            bus.buff_data_in_odd  <= '0;
            bus.wAddr_even        <= '0;
            bus.wAddr_odd         <= '0;
            bus.sat_count         <= '0;
        end else begin
            bus.wEn_even_AH <= {R{v1}};
            bus.wEn_odd_AH  <= {R{v1}};
            if (v1) begin
                bus.buff_data_in_even <= q_even;
                bus.buff_data_in_odd  <= q_odd;
                bus.wAddr_even        <= {R{a1}};
                bus.wAddr_odd         <= {R{a1}};
            end
            if (state == IDLE && bus.start) bus.sat_count <= '0;
            else if (v1)                    bus.sat_count <= sat_next;
        end
    end
endmodule

// File: tb/tb_out_requant_writer.sv
// Self-checking bench for out_requant_writer.
// Honours OUT_REQUANT_RELU_EN when computing expected lane values.
module tb_out_requant_writer;
    localparam int R  = 4;
    localparam int OW = 24;
    localparam int DW = 16;
    localparam int AW = 13;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [R*DW-1:0] de;
        logic [R*DW-1:0] dodd;
        int              cyc;
    } wr_t;

    typedef struct {
        logic [3:0]            s;
        logic signed [OW-1:0]  xe;
        logic signed [OW-1:0]  xo;
        logic signed [DW-1:0]  ye;
        logic signed [DW-1:0]  yo;
        bit                    se;
        bit                    so;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   nwr = 0;
    int   last_cyc = 0;
    int   n0;
    wr_t  exp_q[$];
    vec_t vt[10];

    out_requant_writer_if bus ();

    out_requant_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input int s, input int xe, input int xo,
                                input int ye, input int yo, input bit se, input bit so);
        vec_t v;
        v.s  = 4'(s);
        v.xe = OW'(xe);
        v.xo = OW'(xo);
        v.ye = DW'(ye);
        v.yo = DW'(yo);
        v.se = se;
        v.so = so;
        return v;
    endfunction

    function automatic logic [DW-1:0] rq(input logic signed [DW-1:0] y);
`ifdef OUT_REQUANT_RELU_EN
        return (y < 0) ? '0 : y;
`else
        return y;
`endif
    endfunction

    function automatic int sat_eff(input bit s, input logic signed [DW-1:0] y);
`ifdef OUT_REQUANT_RELU_EN
        return (s && y > 0) ? 1 : 0;
`else
        return s ? 1 : 0;
`endif
    endfunction

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (bus.wEn_even_AH != '0 || bus.wEn_odd_AH != '0)) begin
            wr_t e;
            nwr++;
            chk("wen_even_all", bus.wEn_even_AH, {R{1'b1}});
            chk("wen_odd_all", bus.wEn_odd_AH, {R{1'b1}});
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("waddr_even", bus.wAddr_even, {R{e.addr}});
                chk("waddr_odd", bus.wAddr_odd, {R{e.addr}});
                chk("data_even", bus.buff_data_in_even, e.de);
                chk("data_odd", bus.buff_data_in_odd, e.dodd);
            end
        end
    end

    task automatic start_job(input logic [AW-1:0] b, input int n, input logic [3:0] s);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.base_addr   = b;
        bus.num_outputs = (AW+1)'(n);
        bus.shift_amt   = s;
        last_cyc        = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_rise", bus.busy, 1'b1);
    endtask

    task automatic beat(input logic [R*OW-1:0] e, input logic [R*OW-1:0] o, input bit acc,
                        input logic [AW-1:0] a, input logic [R*DW-1:0] ee,
                        input logic [R*DW-1:0] eo);
        wr_t w;
        @(negedge clk);
        bus.array_out_valid    = 1'b1;
        bus.array_out_even_col = e;
        bus.array_out_odd_col  = o;
        if (acc) begin
            w.addr = a;
            w.de   = ee;
            w.dodd = eo;
            w.cyc  = cyc + 2;
            exp_q.push_back(w);
            last_cyc = cyc;
        end
    endtask

    task automatic wait_done(input string nm);
        bit got = 0;
        int exp_c = last_cyc + 3;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            bus.array_out_valid = 1'b0;
            if (bus.done) got = 1;
        end
        chk({nm, "_done_seen"}, got, 1);
        if (got) begin
            chk({nm, "_done_cycle"}, cyc, exp_c);
            chk({nm, "_busy_fall"}, bus.busy, 1'b0);
            @(negedge clk);
            chk({nm, "_done_pulse"}, bus.done, 1'b0);
        end
        chk({nm, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        vt[0] = mk(4, 24, 24'h7FFFFF, 2, 32767, 0, 1);
        vt[1] = mk(4, -24, -8388608, -1, -32768, 0, 1);
        vt[2] = mk(0, 222, 333, 222, 333, 0, 0);
        vt[3] = mk(0, 40000, -40000, 32767, -32768, 1, 1);
        vt[4] = mk(1, 3, -3, 2, -1, 0, 0);
        vt[5] = mk(15, 24'h7FFFFF, 16384, 256, 1, 0, 0);
        vt[6] = mk(8, 8388352, -8388608, 32767, -32768, 0, 0);
        vt[7] = mk(0, 32767, -32768, 32767, -32768, 0, 0);
        vt[8] = mk(0, -500, 500, -500, 500, 0, 0);
        vt[9] = mk(1, -1, 1, 0, 1, 0, 0);

        bus.start              = 1'b0;
        bus.base_addr          = '0;
        bus.num_outputs        = '0;
        bus.shift_amt          = '0;
        bus.array_out_valid    = 1'b0;
        bus.array_out_even_col = '0;
        bus.array_out_odd_col  = '0;

        repeat (3) @(negedge clk);
        chk("rst_wen_even", bus.wEn_even_AH, '0);
        chk("rst_wen_odd", bus.wEn_odd_AH, '0);
        chk("rst_data", {bus.buff_data_in_even, bus.buff_data_in_odd}, '0);
        chk("rst_addr", {bus.wAddr_even, bus.wAddr_odd}, '0);
        chk("rst_busy_done", {bus.busy, bus.done}, 2'b00);
        chk("rst_sat", bus.sat_count, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);

        // Basic four-beat job from address 0
        n0 = nwr;
        start_job(13'd0, 4, 4'd0);
        for (int i = 0; i < 4; i++)
            beat(96'(24'd222), 96'(24'd333), 1, 13'(i), 64'(16'd222), 64'(16'd333));
        wait_done("basic");
        chk("basic_writes", nwr - n0, 4);

        // Table of requant vectors, one single-beat job each
        for (int i = 0; i < 10; i++) begin
            start_job(13'(1000 + i * 7), 1, vt[i].s);
            beat({R{vt[i].xe}}, {R{vt[i].xo}}, 1, 13'(1000 + i * 7),
                 {R{rq(vt[i].ye)}}, {R{rq(vt[i].yo)}});
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_sat", i), bus.sat_count,
                16'(R * (sat_eff(vt[i].se, vt[i].ye) + sat_eff(vt[i].so, vt[i].yo))));
        end

        // Address wrap; the fourth back-to-back beat must be dropped
        n0 = nwr;
        start_job(13'd8190, 3, 4'd0);
        for (int i = 0; i < 3; i++)
            beat(96'(i + 1), 96'(i + 11), 1, 13'(8190 + i), 64'(i + 1), 64'(i + 11));
        beat({R{24'sd40000}}, {R{24'sd40000}}, 0, '0, '0, '0);
        wait_done("wrap");
        repeat (3) @(negedge clk);
        chk("wrap_writes", nwr - n0, 3);
        chk("wrap_sat", bus.sat_count, 16'd0);

        // Zero-length job
        n0 = nwr;
        start_job(13'd77, 0, 4'd0);
        wait_done("zero");
        chk("zero_writes", nwr - n0, 0);

        // start while busy is ignored
        n0 = nwr;
        start_job(13'd50, 2, 4'd0);
        beat(96'(5), 96'(6), 1, 13'd50, 64'(5), 64'(6));
        bus.start       = 1'b1;
        bus.base_addr   = 13'd900;
        bus.num_outputs = 14'd7;
        beat(96'(7), 96'(8), 1, 13'd51, 64'(7), 64'(8));
        bus.start = 1'b0;
        beat(96'(9), 96'(9), 0, '0, '0, '0);
        wait_done("busy_start");
        repeat (4) @(negedge clk);
        chk("busy_start_writes", nwr - n0, 2);
        chk("busy_start_idle", bus.busy, 1'b0);

        // Long job: sat_count holds at its ceiling, addresses wrap fully
        start_job(13'd5, 8192, 4'd0);
        for (int i = 0; i < 8192; i++)
            beat({R{24'h7FFFFF}}, {R{24'h800000}}, 1, 13'(5 + i),
                 {R{rq(16'sd32767)}}, {R{rq(-16'sd32768)}});
        wait_done("long");
`ifdef OUT_REQUANT_RELU_EN
        chk("long_sat", bus.sat_count, 16'd32768);
`else
        chk("long_sat", bus.sat_count, 16'hFFFF);
`endif

        // Reset in the middle of a five-beat job
        n0 = nwr;
        start_job(13'd200, 5, 4'd0);
        for (int i = 0; i < 3; i++)
            beat(96'(i + 40), 96'(i + 60), 1, 13'(200 + i), 64'(i + 40), 64'(i + 60));
        @(negedge clk);
        bus.array_out_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_writes", nwr - n0, 2);
        chk("mid_rst_wen", {bus.wEn_even_AH, bus.wEn_odd_AH}, '0);
        chk("mid_rst_data", {bus.buff_data_in_even, bus.buff_data_in_odd}, '0);
        chk("mid_rst_addr", {bus.wAddr_even, bus.wAddr_odd}, '0);
        chk("mid_rst_ctl", {bus.busy, bus.done, bus.sat_count}, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_hold", {bus.wEn_even_AH, bus.wEn_odd_AH, bus.done}, '0);
        end
        rst_n = 1'b1;
        n0 = nwr;
        start_job(13'd300, 2, 4'd0);
        beat(96'(1), 96'(2), 1, 13'd300, 64'(1), 64'(2));
        beat(96'(3), 96'(4), 1, 13'd301, 64'(3), 64'(4));
        wait_done("post_rst");
        chk("post_rst_writes", nwr - n0, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
